// File: rtl/tt_um_seg_scan_ctrl.sv
// Multiplexed 4-digit hex seven-segment scanner with a strobe-written digit
// register file. Each digit is lit for DIV clocks, followed by GAP dark clocks.
module tt_um_seg_scan_ctrl #(
    parameter int unsigned DIV = 1000,
    parameter int unsigned GAP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_SHOW = 2'd0,
        ST_GAP  = 2'd1,
        ST_IDLE = 2'd2
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  digit_q [4];
    logic [3:0]  digit_d [4];
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  en_q, en_d;
    logic        sync1_q, sync2_q, hist_q;
    logic        wr_pend_q, ack_q;
    logic        wr_rise;
    logic        blank;
    logic        unused_uio;

    assign unused_uio = &{1'b0, uio_in[7:2]};

    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // The strobe comes from an unrelated source, so it is synchronized first.
    assign wr_rise = sync2_q & ~hist_q;
    assign blank   = ui_in[7] | ~ena;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            digit_d[i] = digit_q[i];
            if (wr_rise && (ui_in[5:4] == 2'(i))) begin
                digit_d[i] = ui_in[3:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (blank) begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                ST_SHOW: begin
                    if (cnt_q >= DIV_LAST) begin
                        state_d = ST_GAP;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q >= GAP_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = 16'd0;
                        // Limit is sampled here so a lowered limit applies at the next advance.
                        idx_d   = (idx_q >= uio_in[1:0]) ? 2'd0 : idx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_SHOW;
                    cnt_d   = 16'd0;
                    idx_d   = 2'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        seg_d = 7'h00;
        en_d  = 4'h0;
        if (state_q == ST_SHOW) begin
            seg_d = hex7seg(digit_q[idx_q]);
            en_d  = 4'b0001 << idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SHOW;
            cnt_q     <= 16'd0;
            idx_q     <= 2'd0;
            seg_q     <= 7'h00;
            en_q      <= 4'h0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            hist_q    <= 1'b0;
            wr_pend_q <= 1'b0;
            ack_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= 4'h0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            en_q      <= en_d;
            sync1_q   <= ui_in[6];
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            wr_pend_q <= wr_rise;
            ack_q     <= wr_pend_q;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    assign uo_out  = {ack_q, seg_q};
    assign uio_out = {4'h0, en_q};
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_seg_scan_ctrl.sv
// Directed bench for tt_um_seg_scan_ctrl: a slot-phase reference model pushes
// expected outputs to a scoreboard queue, popped and checked after each clock.
module tb_tt_um_seg_scan_ctrl;

    localparam int DIV  = 8;
    localparam int GAP  = 2;
    localparam int SLOT = DIV + GAP;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    tt_um_seg_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    typedef struct packed {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t sb_q[$];

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] dig_m [4];
    int         m_ph;
    int         m_idx;
    bit         m_idle;
    int         lim_m;
    int         ack_cd;
    int         strobe_cd;
    int         wr_addr;
    logic [3:0] wr_data;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp_v);
        total_cnt++;
        assert (got === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp_v);
        end
    endtask

    task automatic step(input string tag, input exp_t e);
        exp_t x;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        check8({tag, " uo_out"}, uo_out, x.uo);
        check8({tag, " uio_out"}, uio_out, x.uio);
        $display("t=%0t %s uo_out=%h uio_out=%h exp=%h/%h", $time, tag, uo_out, uio_out, x.uo, x.uio);
    endtask

    // One clock: predict the registered outputs from the model, then advance it.
    task automatic cycle(input string tag);
        exp_t e;
        logic ack_e;
        logic blank_in;
        if (ack_cd == 1) dig_m[wr_addr] = wr_data;
        ack_e = (ack_cd == 1);
        if (ack_cd > 0) ack_cd--;
        if (!m_idle && m_ph < DIV) begin
            e.uo  = {ack_e, seg_of(dig_m[m_idx])};
            e.uio = 8'(1 << m_idx);
        end else begin
            e.uo  = {ack_e, 7'h00};
            e.uio = 8'h00;
        end
        blank_in = ui_in[7] | ~ena;
        step(tag, e);
        if (blank_in) begin
            m_idle = 1'b1;
            m_ph   = 0;
            m_idx  = 0;
        end else if (m_idle) begin
            m_idle = 1'b0;
            m_ph   = 0;
            m_idx  = 0;
        end else begin
            m_ph++;
            if (m_ph == SLOT) begin
                m_ph  = 0;
                m_idx = (m_idx >= lim_m) ? 0 : m_idx + 1;
            end
        end
        if (strobe_cd > 0) begin
            strobe_cd--;
            if (strobe_cd == 0) ui_in[6] = 1'b0;
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    task automatic start_write(input int addr, input logic [3:0] data);
        ui_in[5:4] = 2'(addr);
        ui_in[3:0] = data;
        ui_in[6]   = 1'b1;
        wr_addr    = addr;
        wr_data    = data;
        strobe_cd  = 4;
        ack_cd     = 4;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) dig_m[i] = 4'h0;
        m_ph      = 0;
        m_idx     = 0;
        m_idle    = 1'b0;
        ack_cd    = 0;
        strobe_cd = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t zero_e;
        zero_e = '0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h03;
        lim_m  = 3;
        model_reset();

        // Held in reset: everything dark, pad directions fixed.
        for (int k = 0; k < 3; k++) begin
            step("reset", zero_e);
            check8("reset uio_oe", uio_oe, 8'h0F);
        end
        rst_n = 1'b1;

        // Free-running scan over four digits, all zero.
        run("scan4", 5 * SLOT);

        // Write A to digit 2 while slot 1 is lit; slot 2 must then show 77.
        start_write(2, 4'hA);
        run("write_a", 2 * SLOT + 3);

        // Lower the limit while digit 3 is lit.
        lim_m  = 1;
        uio_in = 8'h01;
        run("limit1", SLOT - 3 + 4 * SLOT);

        // Blank in the middle of a lit slot, then release.
        for (int k = 0; k < SLOT && m_ph != 3; k++) cycle("align");
        ui_in[7] = 1'b1;
        run("blank", 6);
        ui_in[7] = 1'b0;
        run("unblank", SLOT + 2);

        // Disabled for 20 clocks with a write in the middle.
        ena = 1'b0;
        run("ena_off", 5);
        start_write(0, 4'h5);
        run("ena_off_wr", 15);
        ena = 1'b1;
        run("ena_on", SLOT + 5);

        // Reset pulse in the middle of a strobe: no ack, digits cleared.
        start_write(1, 4'h9);
        run("pre_rst", 2);
        ui_in[6] = 1'b0;
        rst_n    = 1'b0;
        #1;
        check8("rst_async uo_out", uo_out, 8'h00);
        check8("rst_async uio_out", uio_out, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run("post_rst", 3 * SLOT);

        check8("scoreboard empty", 8'(sb_q.size()), 8'h00);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
